intrpt_cfg_seq: RTL and testbench

//  Sequencer/host-side controller for intrpt_cntrl. On request it validates a priority table and

---
 rtl/intrpt_pkg.sv | 27 ++
 rtl/intrpt_dup_chk.sv | 36 +++
 rtl/intrpt_cfg_seq.sv | 188 ++++++++++++++++++
 tb/tb_intrpt_cfg_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intrpt_pkg.sv
// Shared types and default sizing for the interrupt configuration sequencer.
package intrpt_pkg;

  function automatic int unsigned tmo_w(input int unsigned max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

  localparam int unsigned NumSlave  = 16;
  localparam int unsigned DataWidth = 4;
  localparam int unsigned Width     = $clog2(NumSlave);
  localparam int unsigned ApbTmo    = 32;
  localparam int unsigned SvcTmo    = 64;
  localparam int unsigned ApbTmoW   = tmo_w(ApbTmo);
  localparam int unsigned SvcTmoW   = tmo_w(SvcTmo);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StSetup,
    StAccess,
    StRun,
    StSvc,
    StAck,
    StDrain
  } seq_state_e;

endpackage

// File: rtl/intrpt_dup_chk.sv
// Seen-bitmap duplicate detector: one bit per possible priority value.
module intrpt_dup_chk #(
  parameter int unsigned data_width = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  chk_i,
  input  logic [data_width-1:0] val_i,
  output logic                  dup_o
);

  localparam int unsigned Bits = 2 ** data_width;

  logic [Bits-1:0] seen_q, seen_d;

  always_comb begin
    seen_d = seen_q;
    if (clr_i) begin
      seen_d = '0;
    end else if (chk_i) begin
      seen_d[val_i] = 1'b1;
    end
  end

  assign dup_o = chk_i & seen_q[val_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen_q <= '0;
    end else begin
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/intrpt_cfg_seq.sv
// Host-side sequencer for intrpt_cntrl: validates and programs the priority table over APB,
// then runs the interrupt service handshake.
module intrpt_cfg_seq
  import intrpt_pkg::*;
#(
  parameter int unsigned num_slave  = NumSlave,
  parameter int unsigned data_width = DataWidth,
  parameter int unsigned width      = $clog2(num_slave),
  parameter int unsigned apb_tmo    = ApbTmo,
  parameter int unsigned svc_tmo    = SvcTmo
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cfg_start,
  input  logic [num_slave*data_width-1:0] cfg_prio,
  output logic                            cfg_busy,
  output logic                            cfg_done,
  output logic                            cfg_err,
  output logic                            psel,
  output logic                            penable,
  output logic                            pwrite,
  output logic [width-1:0]                paddr,
  output logic [data_width-1:0]           pwdata,
  input  logic                            pready,
  input  logic                            perror,
  input  logic                            intrt_valid,
  input  logic [width-1:0]                intrt_to_be_servised,
  output logic                            intrt_servised,
  output logic                            hdl_req,
  output logic [width-1:0]                hdl_id,
  input  logic                            hdl_done,
  output logic                            svc_tmo_err
);

  localparam int unsigned TmoMax = (apb_tmo > svc_tmo) ? apb_tmo : svc_tmo;
  localparam int unsigned TmoW   = tmo_w(TmoMax);
  localparam logic [width-1:0] IdxLast   = width'(num_slave - 1);
  localparam logic [TmoW-1:0]  ApbLimit  = TmoW'(apb_tmo - 1);
  localparam logic [TmoW-1:0]  SvcLimit  = TmoW'(svc_tmo - 1);

  seq_state_e            state_q, state_d;
  logic [width-1:0]      idx_q, idx_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [width-1:0]      hdl_id_q, hdl_id_d;
  logic [data_width-1:0] prio_q [num_slave];
  logic [data_width-1:0] prio_d [num_slave];
  logic cfg_done_q, cfg_done_d, cfg_err_q, cfg_err_d, svc_tmo_err_q, svc_tmo_err_d;
  logic seen_clr, seen_chk, seen_dup;

  intrpt_dup_chk #(
    .data_width(data_width)
  ) u_dup_chk (
    .clk_i (clk),
    .rst_ni(rstn),
    .clr_i (seen_clr),
    .chk_i (seen_chk),
    .val_i (prio_q[idx_q]),
    .dup_o (seen_dup)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      tmo_q         <= '0;
      hdl_id_q      <= '0;
      prio_q        <= '{default: '0};
      cfg_done_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      svc_tmo_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      hdl_id_q      <= hdl_id_d;
      prio_q        <= prio_d;
      cfg_done_q    <= cfg_done_d;
      cfg_err_q     <= cfg_err_d;
      svc_tmo_err_q <= svc_tmo_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    hdl_id_d      = hdl_id_q;
    prio_d        = prio_q;
    cfg_done_d    = 1'b0;
    cfg_err_d     = 1'b0;
    svc_tmo_err_d = 1'b0;
    seen_clr      = 1'b0;
    seen_chk      = 1'b0;
    if (tmo_q != '1) tmo_d = tmo_q + 1'b1;

    unique case (state_q)
      StIdle, StRun: begin
        // A new table request outranks a pending interrupt in RUN.
        if (cfg_start) begin
          for (int i = 0; i < num_slave; i++) begin
            prio_d[i] = cfg_prio[i*data_width +: data_width];
          end
          idx_d    = '0;
          seen_clr = 1'b1;
          state_d  = StCheck;
        end else if (state_q == StRun && intrt_valid) begin
          hdl_id_d = intrt_to_be_servised;
          state_d  = StSvc;
        end
      end
      StCheck: begin
        seen_chk = 1'b1;
        if (seen_dup) begin
          cfg_err_d = 1'b1;
          state_d   = StIdle;
        end else if (idx_q == IdxLast) begin
          idx_d   = '0;
          state_d = StSetup;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (pready) begin
          if (perror) begin
            cfg_err_d = 1'b1;
            state_d   = StIdle;
          end else if (idx_q == IdxLast) begin
            cfg_done_d = 1'b1;
            state_d    = StRun;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StSetup;
          end
        end else if (tmo_q >= ApbLimit) begin
          cfg_err_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StSvc: begin
        if (hdl_done) begin
          state_d = StAck;
        end else if (tmo_q >= SvcLimit) begin
          svc_tmo_err_d = 1'b1;
          state_d       = StAck;
        end
      end
      StAck: state_d = StDrain;
      // Hold off until the serviced winner is withdrawn so it is not taken twice.
      StDrain: if (!intrt_valid) state_d = StRun;
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) tmo_d = '0;
  end

  always_comb begin
    psel           = 1'b0;
    penable        = 1'b0;
    cfg_busy       = 1'b0;
    hdl_req        = 1'b0;
    intrt_servised = 1'b0;
    unique case (state_q)
      StCheck:  cfg_busy = 1'b1;
      StSetup: begin
        cfg_busy = 1'b1;
        psel     = 1'b1;
      end
      StAccess: begin
        cfg_busy = 1'b1;
        psel     = 1'b1;
        penable  = 1'b1;
      end
      StSvc:    hdl_req = 1'b1;
      StAck:    intrt_servised = 1'b1;
      default: ;
    endcase
    pwrite      = psel;
    paddr       = psel ? idx_q : '0;
    pwdata      = psel ? prio_q[idx_q] : '0;
    hdl_id      = hdl_id_q;
    cfg_done    = cfg_done_q;
    cfg_err     = cfg_err_q;
    svc_tmo_err = svc_tmo_err_q;
  end

endmodule

// File: tb/tb_intrpt_cfg_seq.sv
// Directed bench for intrpt_cfg_seq: table programming, error paths, service handshake, reset.
module tb_intrpt_cfg_seq;

  localparam int unsigned NS = 16;
  localparam int unsigned DW = 4;
  localparam int unsigned W  = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cfg_start = 1'b0;
  logic [NS*DW-1:0] cfg_prio = '0;
  logic            cfg_busy, cfg_done, cfg_err;
  logic            psel, penable, pwrite;
  logic [W-1:0]    paddr;
  logic [DW-1:0]   pwdata;
  logic            pready, perror;
  logic            intrt_valid = 1'b0;
  logic [W-1:0]    intrt_to_be_servised = '0;
  logic            intrt_servised, hdl_req;
  logic [W-1:0]    hdl_id;
  logic            hdl_done = 1'b0;
  logic            svc_tmo_err;

  logic         stall_en = 1'b0, perr_en = 1'b0;
  logic [W-1:0] stall_addr = '0, perr_addr = '0;

  assign pready = !(stall_en && psel && paddr == stall_addr);
  assign perror = perr_en && psel && paddr == perr_addr;

  always #5 clk = ~clk;

  intrpt_cfg_seq dut (
    .clk                 (clk),
    .rstn                (rstn),
    .cfg_start           (cfg_start),
    .cfg_prio            (cfg_prio),
    .cfg_busy            (cfg_busy),
    .cfg_done            (cfg_done),
    .cfg_err             (cfg_err),
    .psel                (psel),
    .penable             (penable),
    .pwrite              (pwrite),
    .paddr               (paddr),
    .pwdata              (pwdata),
    .pready              (pready),
    .perror              (perror),
    .intrt_valid         (intrt_valid),
    .intrt_to_be_servised(intrt_to_be_servised),
    .intrt_servised      (intrt_servised),
    .hdl_req             (hdl_req),
    .hdl_id              (hdl_id),
    .hdl_done            (hdl_done),
    .svc_tmo_err         (svc_tmo_err)
  );

  // Completed writes and pulse counts, observed mid-cycle.
  logic [7:0] wr_q[$];
  int srv_cnt = 0, err_cnt = 0, slot3_cnt = 0;
  always @(negedge clk) begin
    if (psel && penable && pready && !perror) wr_q.push_back({paddr, pwdata});
    if (intrt_servised) srv_cnt <= srv_cnt + 1;
    if (cfg_err) err_cnt <= err_cnt + 1;
    if (psel && paddr == 4'd3) slot3_cnt <= slot3_cnt + 1;
  end

  int n_pass = 0, n_chk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cfg(input logic [NS*DW-1:0] tbl);
    cfg_prio  = tbl;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {cfg_busy, cfg_done, cfg_err, psel, penable, pwrite, paddr, pwdata,
            intrt_servised, hdl_req, hdl_id, svc_tmo_err};
  endfunction

  initial begin
    logic [NS*DW-1:0] asc, dup;
    int base_w, base_e, base_s, base_3, done_cyc, err_cyc, req_cyc, acc5;
    logic found;

    for (int i = 0; i < NS; i++) asc[i*DW +: DW] = 4'(i);
    dup = asc;
    dup[3*DW +: DW] = 4'd7;
    dup[7*DW +: DW] = 4'd3;
    dup[9*DW +: DW] = 4'd7;

    repeat (2) tick();
    check("reset_outputs", all_outs(), 0);
    rstn = 1'b1;
    tick();

    // Ascending table, zero wait states.
    base_w = wr_q.size();
    base_e = err_cnt;
    start_cfg(asc);
    check("busy_cycle1", cfg_busy, 1);
    done_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      if (cfg_done && done_cyc == 0) done_cyc = c;
      tick();
    end
    check("done_cycle", done_cyc, 49);
    check("asc_wr_count", wr_q.size() - base_w, 16);
    for (int i = 0; i < NS; i++) check($sformatf("asc_wr_%0d", i), wr_q[base_w+i], {4'(i), 4'(i)});
    check("asc_no_err", err_cnt - base_e, 0);
    check("asc_idle_bus", {cfg_busy, psel}, 0);

    // Service handshake with stale valid held through DRAIN.
    base_s = srv_cnt;
    intrt_valid = 1'b1;
    intrt_to_be_servised = 4'd4;
    tick();
    check("req_id", {hdl_req, hdl_id}, {1'b1, 4'd4});
    tick();
    check("req_level", hdl_req, 1);
    hdl_done = 1'b1;
    tick();
    hdl_done = 1'b0;
    check("ack", {intrt_servised, hdl_req}, 2'b10);
    start_cfg(asc);
    check("drain_state", {intrt_servised, cfg_busy, hdl_req}, 0);
    repeat (4) tick();
    check("no_second_req", {hdl_req, cfg_busy}, 0);
    check("one_servised", srv_cnt - base_s, 1);
    intrt_valid = 1'b0;
    tick();

    // Handler never finishes.
    intrt_valid = 1'b1;
    intrt_to_be_servised = 4'd9;
    tick();
    intrt_valid = 1'b0;
    req_cyc = 0;
    for (int c = 0; c < 100; c++) begin
      if (!hdl_req) break;
      req_cyc++;
      tick();
    end
    check("svc_tmo_cycles", req_cyc, 64);
    check("svc_tmo_ack", {svc_tmo_err, intrt_servised, hdl_id}, {1'b1, 1'b1, 4'd9});
    tick();
    check("svc_tmo_pulse", {svc_tmo_err, intrt_servised}, 0);
    tick();

    // Duplicate priority; reconfig request beats a pending interrupt.
    intrt_valid = 1'b1;
    intrt_to_be_servised = 4'd2;
    base_w = wr_q.size();
    base_e = err_cnt;
    start_cfg(dup);
    check("reconfig_priority", {cfg_busy, hdl_req}, 2'b10);
    err_cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      if (cfg_err && err_cyc == 0) err_cyc = c;
      tick();
    end
    check("dup_err_cycle", err_cyc, 11);
    check("dup_no_writes", wr_q.size() - base_w, 0);
    check("dup_err_count", err_cnt - base_e, 1);
    check("dup_idle", {cfg_busy, hdl_req, psel}, 0);
    intrt_valid = 1'b0;

    // APB timeout on slot 5.
    stall_addr = 4'd5;
    stall_en = 1'b1;
    base_w = wr_q.size();
    base_e = err_cnt;
    start_cfg(asc);
    acc5 = 0;
    for (int c = 1; c <= 150; c++) begin
      if (psel && penable && paddr == 4'd5) acc5++;
      tick();
    end
    check("apb_tmo_cycles", acc5, 32);
    check("apb_tmo_writes", wr_q.size() - base_w, 5);
    check("apb_tmo_err", err_cnt - base_e, 1);
    check("apb_tmo_bus", {psel, penable}, 0);
    stall_en = 1'b0;

    // Slave error on slot 2.
    perr_addr = 4'd2;
    perr_en = 1'b1;
    base_w = wr_q.size();
    base_e = err_cnt;
    base_3 = slot3_cnt;
    start_cfg(asc);
    repeat (60) tick();
    check("perr_writes", wr_q.size() - base_w, 2);
    check("perr_err", err_cnt - base_e, 1);
    check("perr_no_slot3", slot3_cnt - base_3, 0);
    perr_en = 1'b0;

    // Asynchronous reset during ACCESS of slot 8.
    start_cfg(asc);
    found = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (psel && penable && paddr == 4'd8) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reach_slot8", found, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    tick();
    rstn = 1'b1;
    intrt_valid = 1'b1;
    intrt_to_be_servised = 4'd5;
    repeat (3) tick();
    check("valid_ignored_after_reset", {hdl_req, cfg_busy}, 0);
    start_cfg(asc);
    for (int c = 1; c <= 60; c++) begin
      if (cfg_done) break;
      tick();
    end
    check("reprogram_done", cfg_done, 1);
    tick();
    check("service_after_reprogram", {hdl_req, hdl_id}, {1'b1, 4'd5});
    intrt_valid = 1'b0;
    hdl_done = 1'b1;
    tick();
    hdl_done = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
